// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, iterative-unit FSM states and context.
package ex_pkg;

    localparam int EX_WIDTH = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_REM = 4'd12;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    // Operand facts captured at start; magnitudes live in the datapath registers.
    typedef struct packed {
        logic       sign_a;
        logic       sign_b;
        logic       b_zero;
        logic [3:0] op;
    } md_ctx_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed MUL/DIV/REM on magnitudes: one step per falling edge, WIDTH steps, then one DONE cycle.
// No backpressure: start is honoured only in IDLE; busy/done tell the caller when to hold and when to sample.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state, state_nxt;
    md_ctx_t          ctx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;    // product accumulator or partial remainder
    logic [WIDTH-1:0] sh_q;   // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [WIDTH-1:0] sh_m;   // multiplicand (shifts left) or divisor (static)

    logic [WIDTH-1:0] acc_n, sh_q_n, sh_m_n, result_fin;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   trial, diff;
    logic             last;

    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign last  = (count == CW'(WIDTH - 1));

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic s);
        return s ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        trial  = {acc, sh_q[WIDTH-1]};
        diff   = trial - {1'b0, sh_m};
        acc_n  = acc;
        sh_q_n = sh_q;
        sh_m_n = sh_m;
        if (ctx.op == OP_MUL) begin
            acc_n  = acc + (sh_q[0] ? sh_m : '0);
            sh_q_n = sh_q >> 1;
            sh_m_n = sh_m << 1;
        end else begin
            acc_n  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            sh_q_n = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    always_comb begin
        result_fin = '0;
        case (ctx.op)
            OP_MUL:  result_fin = neg_if(acc_n, ctx.sign_a ^ ctx.sign_b);
            OP_DIV:  result_fin = ctx.b_zero ? '1 : neg_if(sh_q_n, ctx.sign_a ^ ctx.sign_b);
            OP_REM:  result_fin = neg_if(acc_n, ctx.sign_a);
            default: result_fin = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (last)  state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            count  <= '0;
            result <= '0;
            acc    <= '0;
            sh_q   <= '0;
            sh_m   <= '0;
            ctx    <= '0;
        end else if (state == MD_IDLE) begin
            if (start) begin
                count      <= '0;
                acc        <= '0;
                ctx.sign_a <= a[WIDTH-1];
                ctx.sign_b <= b[WIDTH-1];
                ctx.b_zero <= (b == '0);
                ctx.op     <= op;
                sh_q       <= (op == OP_MUL) ? mag_b : mag_a;
                sh_m       <= (op == OP_MUL) ? mag_a : mag_b;
            end
        end else if (state == MD_BUSY) begin
            acc   <= acc_n;
            sh_q  <= sh_q_n;
            sh_m  <= sh_m_n;
            count <= count + 1'b1;
            if (last) begin
                result <= result_fin;
            end
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, branch resolution and EX/MEM control gating.
// Single-cycle ops have zero latency; MUL/DIV/REM hold the pipeline with stall for WIDTH+1 cycles.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic [3:0]       ALUOp,
    input  logic             NotEqual,
    input  logic             IsBranch,
    input  logic [WIDTH-1:0] ALUVal1,
    input  logic [WIDTH-1:0] ALUVal2,
    input  logic [WIDTH-1:0] readReg2In,
    input  logic [WIDTH-1:0] branchAddr,
    input  logic [4:0]       destIn,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchTarget,
    output logic             stall,
    output logic             RegWriteOut,
    output logic             MemReadOut,
    output logic             MemWriteOut,
    output logic [WIDTH-1:0] readReg2Out,
    output logic [4:0]       destOut
);

    logic             long_op;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] alu_comb;
    logic [4:0]       shamt;

    assign long_op = is_long_op(ALUOp);
    assign shamt   = ALUVal2[4:0];

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (long_op),
        .op     (ALUOp),
        .a      (ALUVal1),
        .b      (ALUVal2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_comb = '0;
        case (ALUOp)
            OP_ADD:  alu_comb = ALUVal1 + ALUVal2;
            OP_SUB:  alu_comb = ALUVal1 - ALUVal2;
            OP_AND:  alu_comb = ALUVal1 & ALUVal2;
            OP_OR:   alu_comb = ALUVal1 | ALUVal2;
            OP_XOR:  alu_comb = ALUVal1 ^ ALUVal2;
            OP_NOR:  alu_comb = ~(ALUVal1 | ALUVal2);
            OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, $signed(ALUVal1) < $signed(ALUVal2)};
            OP_SLL:  alu_comb = ALUVal1 << shamt;
            OP_SRL:  alu_comb = ALUVal1 >> shamt;
            OP_SRA:  alu_comb = $signed(ALUVal1) >>> shamt;
            default: alu_comb = '0;
        endcase
    end

    // The DONE cycle releases the stall so EX/MEM captures the iterative result.
    assign stall        = md_busy | (long_op & ~md_done);
    assign aluResult    = long_op ? md_result : alu_comb;
    assign zero         = (aluResult == '0);
    assign branchTaken  = IsBranch & (zero ^ NotEqual) & ~stall;
    assign branchTarget = branchAddr;
    assign RegWriteOut  = RegWriteIn & ~stall;
    assign MemReadOut   = MemReadIn & ~stall;
    assign MemWriteOut  = MemWriteIn & ~stall;
    assign readReg2Out  = readReg2In;
    assign destOut      = destIn;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; inputs change just after the falling edge, outputs sampled on the rising edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteIn, MemReadIn, MemWriteIn;
    logic [3:0]  ALUOp;
    logic        NotEqual, IsBranch;
    logic [31:0] ALUVal1, ALUVal2, readReg2In, branchAddr;
    logic [4:0]  destIn;
    logic [31:0] aluResult, branchTarget, readReg2Out;
    logic        zero, branchTaken, stall, RegWriteOut, MemReadOut, MemWriteOut;
    logic [4:0]  destOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteIn   (RegWriteIn),
        .MemReadIn    (MemReadIn),
        .MemWriteIn   (MemWriteIn),
        .ALUOp        (ALUOp),
        .NotEqual     (NotEqual),
        .IsBranch     (IsBranch),
        .ALUVal1      (ALUVal1),
        .ALUVal2      (ALUVal2),
        .readReg2In   (readReg2In),
        .branchAddr   (branchAddr),
        .destIn       (destIn),
        .aluResult    (aluResult),
        .zero         (zero),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .stall        (stall),
        .RegWriteOut  (RegWriteOut),
        .MemReadOut   (MemReadOut),
        .MemWriteOut  (MemWriteOut),
        .readReg2Out  (readReg2Out),
        .destOut      (destOut)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        ALUOp   = op;
        ALUVal1 = a;
        ALUVal2 = b;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b);
        @(posedge clk);
        check(tag, aluResult, exp);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    endtask

    task automatic long_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int cycles;
        logic gated_leak;
        drive(op, a, b);
        cycles     = 0;
        gated_leak = 1'b0;
        @(posedge clk);
        while (stall && cycles < 100) begin
            if (RegWriteOut || MemWriteOut || MemReadOut) gated_leak = 1'b1;
            cycles++;
            @(posedge clk);
        end
        check({tag, "_lat"}, cycles, 32'd33);
        check({tag, "_gate"}, {31'b0, gated_leak}, 32'd0);
        check(tag, aluResult, exp);
        check({tag, "_wr"}, {31'b0, RegWriteOut}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        RegWriteIn = 1'b1;
        MemReadIn  = 1'b1;
        MemWriteIn = 1'b1;
        ALUOp      = 4'd0;
        NotEqual   = 1'b0;
        IsBranch   = 1'b0;
        ALUVal1    = 32'd0;
        ALUVal2    = 32'd0;
        readReg2In = 32'hCAFE_F00D;
        branchAddr = 32'h0040_0100;
        destIn     = 5'd17;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        @(posedge clk);
        check("rst_result", aluResult, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("pass_rr2", readReg2Out, 32'hCAFE_F00D);
        check("pass_dest", {27'b0, destOut}, 32'd17);

        alu_vec("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        check("add_zero", {31'b0, zero}, 32'd0);
        alu_vec("slt_neg", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("slt_pos", 4'd6, 32'd1, 32'hFFFF_FFFF, 32'd0);
        alu_vec("sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_vec("srl", 4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_vec("sll", 4'd7, 32'd1, 32'h0000_003F, 32'h8000_0000);
        alu_vec("nor", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF);
        alu_vec("xor", 4'd4, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
        alu_vec("rsvd", 4'd14, 32'd3, 32'd4, 32'd0);

        IsBranch = 1'b1;
        alu_vec("beq_sub", 4'd1, 32'd5, 32'd5, 32'd0);
        check("beq_taken", {31'b0, branchTaken}, 32'd1);
        check("br_target", branchTarget, 32'h0040_0100);
        NotEqual = 1'b1;
        #1;
        check("bne_taken", {31'b0, branchTaken}, 32'd0);
        IsBranch = 1'b0;
        NotEqual = 1'b0;

        long_vec("mul", 4'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        long_vec("div", 4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        long_vec("rem", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        long_vec("div0", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF);
        long_vec("rem0", 4'd12, 32'd9, 32'd0, 32'd9);
        long_vec("rem0_neg", 4'd12, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
        long_vec("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        long_vec("rem_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        long_vec("b2b_mul", 4'd10, 32'd1000, 32'd1000, 32'd1_000_000);
        long_vec("b2b_div", 4'd11, 32'd100, 32'd7, 32'd14);

        // Abort a multiply partway through the iteration.
        drive(4'd10, 32'd12345, 32'd678);
        repeat (11) @(negedge clk);
        @(posedge clk);
        check("mid_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        reset   = 1'b0;
        ALUOp   = 4'd0;
        ALUVal1 = 32'd2;
        ALUVal2 = 32'd3;
        @(posedge clk);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_add", aluResult, 32'd5);
        long_vec("post_rst_mul", 4'd10, 32'd6, 32'd7, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
